// File: rtl/c_mem_writer.sv
// Result-matrix store: collects one ELEMENT_WIDTH word per row over valid/ready,
// raises finish once every row has arrived, and offers a registered read port.
module c_mem_writer #(
  parameter  int C_MEM_HEIGHT  = 64,
  parameter  int ELEMENT_WIDTH = 32,
  localparam int ROW_W         = $clog2(C_MEM_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     wr_valid,
  input  logic [ROW_W-1:0]         wr_row,
  input  logic [ELEMENT_WIDTH-1:0] wr_data,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [ROW_W-1:0]         rd_row,
  output logic [ELEMENT_WIDTH-1:0] rd_data,
  output logic                     rd_valid,
  output logic [ROW_W:0]           wr_count,
  output logic                     finish,
  output logic                     busy,
  output logic                     dup_err,
  output logic                     range_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam logic [ROW_W:0] HEIGHT = (ROW_W+1)'(C_MEM_HEIGHT);
  localparam logic [ROW_W:0] ONE    = (ROW_W+1)'(1);

  state_t                     state, next_state;
  logic [ELEMENT_WIDTH-1:0]   mem [C_MEM_HEIGHT];
  logic [C_MEM_HEIGHT-1:0]    written;

  logic accept, wr_in_range, rd_in_range, row_seen;
  logic wr_new, wr_dup, wr_oor, last_write;

  // start takes priority over any write presented in the same cycle
  assign accept      = wr_valid && wr_ready && !start;
  assign wr_in_range = {1'b0, wr_row} < HEIGHT;
  assign rd_in_range = {1'b0, rd_row} < HEIGHT;
  assign row_seen    = wr_in_range && written[wr_row];
  assign wr_new      = accept && wr_in_range && !row_seen;
  assign wr_dup      = accept && row_seen;
  assign wr_oor      = accept && !wr_in_range;
  assign last_write  = wr_new && (wr_count == HEIGHT - ONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    if (start)
      next_state = COLLECT;
    else if (state == COLLECT && last_write)
      next_state = DONE;
  end

  always_comb begin
    wr_ready = 1'b0;
    busy     = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE:    ;
      COLLECT: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written   <= '0;
      wr_count  <= '0;
      dup_err   <= 1'b0;
      range_err <= 1'b0;
    end else if (start) begin
      written   <= '0;
      wr_count  <= '0;
      dup_err   <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (wr_new) begin
        written[wr_row] <= 1'b1;
        wr_count        <= wr_count + ONE;
      end
      if (wr_dup) dup_err   <= 1'b1;
      if (wr_oor) range_err <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately left without a reset; only the
  // bitmap says which rows hold valid results, so clearing data buys nothing.
  always_ff @(posedge clk) begin
    if (wr_new) mem[wr_row] <= wr_data;
  end

  // Same-row read and write in one cycle returns the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_row] : '0;
    end
  end

endmodule

// File: tb/tb_c_mem_writer.sv
// Self-checking bench for c_mem_writer: directed scenarios plus random traffic,
// compared every cycle against a row-set/count model of the result store.
module tb_c_mem_writer;
  localparam int H  = 64;
  localparam int W  = 32;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, wr_valid = 1'b0, rd_en = 1'b0;
  logic [RW-1:0] wr_row = '0, rd_row = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_ready, rd_valid, finish, busy, dup_err, range_err;
  logic [W-1:0]  rd_data;
  logic [RW:0]   wr_count;

  c_mem_writer #(.C_MEM_HEIGHT(H), .ELEMENT_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_count(wr_count), .finish(finish), .busy(busy),
    .dup_err(dup_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: set of rows seen since start, their count, and a data array.
  logic [W-1:0] m_mem   [H];
  bit           m_known [H];
  bit           m_seen  [H];
  int           m_count;
  bit           m_armed, m_dup, m_rng, m_rd_valid, m_rd_known;
  logic [W-1:0] m_rd_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_seen[i]) m_seen[i] = 1'b0;
      m_count = 0; m_armed = 0; m_dup = 0; m_rng = 0;
      m_rd_valid = 0; m_rd_data = '0; m_rd_known = 1;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) begin
        if (int'(rd_row) < H) begin
          m_rd_data  = m_mem[rd_row];
          m_rd_known = m_known[rd_row];
        end else begin
          m_rd_data  = '0;
          m_rd_known = 1;
        end
      end
      if (start) begin
        foreach (m_seen[i]) m_seen[i] = 1'b0;
        m_count = 0; m_dup = 0; m_rng = 0; m_armed = 1;
      end else if (m_armed && m_count < H && wr_valid) begin
        if (int'(wr_row) >= H) m_rng = 1;
        else if (m_seen[wr_row]) m_dup = 1;
        else begin
          m_mem[wr_row]   = wr_data;
          m_known[wr_row] = 1;
          m_seen[wr_row]  = 1;
          m_count++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("wr_ready",  wr_ready,  m_armed && m_count < H);
      check("busy",      busy,      m_armed && m_count < H);
      check("finish",    finish,    m_armed && m_count == H);
      check("wr_count",  wr_count,  m_count);
      check("dup_err",   dup_err,   m_dup);
      check("range_err", range_err, m_rng);
      check("rd_valid",  rd_valid,  m_rd_valid);
      if (m_rd_known) check("rd_data", rd_data, m_rd_data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wr(input int row, input logic [W-1:0] data);
    wr_valid = 1'b1; wr_row = RW'(row); wr_data = data; tick(); wr_valid = 1'b0;
  endtask

  task automatic rd(input int row);
    rd_en = 1'b1; rd_row = RW'(row); tick(); rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_data",  rd_data,  0);
    check("rst_wr_count", wr_count, 0);
    check("rst_finish",   finish,   0);
    rst_n = 1'b1;
    check_en = 1'b1;
    tick();

    // In-order fill with wr_valid held high.
    do_start();
    for (int r = 0; r < H; r++) begin
      if (r == 63) begin
        check("cnt_63", wr_count, 63);
        check("fin_63", finish, 0);
      end
      wr_valid = 1'b1; wr_row = RW'(r); wr_data = 32'h1000 + r;
      tick();
    end
    wr_valid = 1'b0;
    check("fill_finish",   finish,   1);
    check("fill_count",    wr_count, 64);
    check("fill_wr_ready", wr_ready, 0);
    rd(5);
    check("rd5_valid", rd_valid, 1);
    check("rd5_data",  rd_data,  32'h0000_1005);
    tick();
    check("rd_hold_valid", rd_valid, 0);
    check("rd_hold_data",  rd_data,  32'h0000_1005);
    wr(0, 32'hDEAD);
    check("done_wr_ignored", wr_count, 64);
    rd(0);
    check("rd0_data", rd_data, 32'h0000_1000);

    // Reverse-order fill with wr_valid toggling.
    do_start();
    for (int i = 0; i < 2 * H; i++) begin
      wr_valid = ~i[0]; wr_row = RW'(63 - i / 2); wr_data = $urandom;
      tick();
    end
    wr_valid = 1'b0;
    check("rev_finish", finish,  1);
    check("rev_dup",    dup_err, 0);
    for (int r = 0; r < H; r++) rd(r);

    // Duplicate write keeps the first value.
    do_start();
    wr(7, 32'hAAAA);
    wr(7, 32'hBBBB);
    check("dup_flag",  dup_err,  1);
    check("dup_count", wr_count, 1);
    rd(7);
    check("dup_rd7", rd_data, 32'h0000_AAAA);

    // Read-before-write on the same row.
    do_start();
    wr(3, 32'h11);
    do_start();
    rd_en = 1'b1; rd_row = RW'(3);
    wr_valid = 1'b1; wr_row = RW'(3); wr_data = 32'h22;
    tick();
    rd_en = 1'b0; wr_valid = 1'b0;
    check("rbw_old", rd_data, 32'h11);
    rd(3);
    check("rbw_new", rd_data, 32'h22);

    // start colliding with a write after 30 rows.
    do_start();
    for (int r = 0; r < 30; r++) wr(r, $urandom);
    wr(0, 32'h5);
    check("pre_start_dup", dup_err, 1);
    start = 1'b1; wr_valid = 1'b1; wr_row = RW'(31); wr_data = 32'hCAFE;
    tick();
    start = 1'b0; wr_valid = 1'b0;
    check("coll_count", wr_count, 0);
    check("coll_dup",   dup_err,  0);
    check("coll_busy",  busy,     1);
    rd(31);
    check("coll_row31_kept", rd_data == 32'hCAFE, 0);
    wr(31, 32'h1);
    check("coll_row31_new", wr_count, 1);

    // Asynchronous reset in the middle of a cycle.
    do_start();
    for (int r = 0; r < 9; r++) wr(r, $urandom);
    rd_en = 1'b1; rd_row = RW'(1);
    wr(0, 32'h77);
    rd_en = 1'b0;
    check("pre_rst_valid", rd_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count",    wr_count, 0);
    check("arst_busy",     busy,     0);
    check("arst_wr_ready", wr_ready, 0);
    check("arst_dup",      dup_err,  0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data",  rd_data,  0);
    tick();
    rst_n = 1'b1;
    wr(2, 32'h9);
    wr(3, 32'h9);
    check("post_rst_count", wr_count, 0);
    check("post_rst_ready", wr_ready, 0);

    // Random traffic.
    do_start();
    repeat (3000) begin
      start    = ($urandom_range(0, 499) == 0);
      wr_valid = ($urandom_range(0, 9) < 7);
      wr_row   = RW'($urandom);
      wr_data  = $urandom;
      rd_en    = $urandom_range(0, 1) == 1;
      rd_row   = RW'($urandom);
      tick();
    end
    start = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/c_mem_writer.md
Name: c_mem_writer

Overview:
- Result-matrix store at the output end of the matrix-multiply datapath; the write-side counterpart of the B/A row-fetch memories.
- Accepts one ELEMENT_WIDTH result word per row from the compute array over a valid/ready handshake.
- Tracks which rows have been written and raises finish once every row of the matrix has arrived.
- Provides a registered read port so the host/readout logic can drain results.

Parameters:
C_MEM_HEIGHT, 64, number of rows (result words) per matrix
ELEMENT_WIDTH, 32, bits per stored element
ROW_W, $clog2(C_MEM_HEIGHT), width of row index (derived, not overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin collecting a new result matrix
wr_valid  input  1  compute array presents a result element
wr_row  input  ROW_W  target row of the presented element
wr_data  input  ELEMENT_WIDTH  result element
wr_ready  output  1  block accepts a write this cycle
rd_en  input  1  read request
rd_row  input  ROW_W  row to read
rd_data  output  ELEMENT_WIDTH  registered read data
rd_valid  output  1  rd_data valid (one cycle after rd_en)
wr_count  output  ROW_W+1  number of distinct rows written since start
finish  output  1  all C_MEM_HEIGHT rows written
busy  output  1  collecting (state COLLECT)
dup_err  output  1  sticky: a row was written twice
range_err  output  1  sticky: wr_row >= C_MEM_HEIGHT

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, wr_ready 0, rd_data 0, rd_valid 0, wr_count 0, finish 0, busy 0, dup_err 0, range_err 0, written-row bitmap all 0. Storage array contents are not reset.
- Reset mid-operation aborts collection immediately; no partial state survives.
- FSM states:
  - IDLE: wr_ready 0; start -> COLLECT.
  - COLLECT: wr_ready 1, busy 1.
  - DONE: wr_ready 0, finish 1.
- On start, from any state:
  - Clear bitmap, wr_count, dup_err, range_err and finish.
  - Enter COLLECT next cycle.
  - Stored data is kept.
- Write handshake: accepted when wr_valid && wr_ready in COLLECT. Outcomes by case:
  - Normal (row in range, bitmap bit clear): store wr_data at wr_row, set the bit, increment wr_count.
  - Duplicate (row in range, bit already set): data ignored (first value kept), dup_err set, wr_count unchanged.
  - Out of range (wr_row >= C_MEM_HEIGHT): nothing stored, range_err set.
- start and an accepted write in the same cycle: start wins; the write is dropped and not counted.
- Completion: the cycle after wr_count reaches C_MEM_HEIGHT, state is DONE, finish 1, wr_ready 0.
  - The last write in COLLECT is accepted normally.
  - finish stays high until start or reset.
- Writes presented in IDLE or DONE are not accepted (wr_ready 0), and no error flags change.
- Read port:
  - Allowed in every state.
  - rd_en at edge N -> rd_data = mem[rd_row] and rd_valid 1 after edge N+1.
  - rd_valid is 0 in any cycle without a preceding rd_en.
  - rd_data holds its last value when rd_valid is 0.
  - rd_row out of range returns 0 with rd_valid 1.
- Read and write to the same row in the same cycle: read returns the old contents (read-before-write).
- Errors are sticky; they do not block further writes or completion.

Test Plan:
- Reset then start; write rows 0..63 in order with data 0x1000+row, wr_valid held high -> wr_count counts 1..64, finish rises the cycle after the 64th write, wr_ready drops; readback of row 5 gives 0x00001005 one cycle after rd_en.
- Reverse-order writes 63..0 with wr_valid toggling every other cycle -> finish only after all 64 rows; no errors; every readback matches.
- Write row 7 = 0xAAAA then row 7 = 0xBBBB -> dup_err 1, wr_count 1, readback row 7 = 0x0000AAAA.
- Same-cycle rd_en and write to row 3, old value 0x11, new value 0x22 -> rd_data 0x11; the next read returns 0x22.
- After 30 rows, pulse start together with wr_valid on row 31 -> wr_count 0, errors cleared, row 31 not written, still COLLECT.
- Assert rst_n low mid-collection after 10 writes -> all outputs return to reset values asynchronously; writes are not accepted until the next start.
